// File: rtl/fft_drv_pkg.sv
// Shared types and helpers for the FFT butterfly operand sequencer.
// Build option: FFT_DRV_CLEAR_STEP_EN adds the trailing CLEAR press.
package fft_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    DONE
  } drv_state_t;

  // Press k moves the butterfly controller into step k.
  typedef enum logic [3:0] {
    STORE_W   = 4'd0,
    STORE_B   = 4'd1,
    CALC_REWB = 4'd2,
    CALC_IMY  = 4'd3,
    CALC_IMZ  = 4'd4,
    STORE_A   = 4'd5,
    CALC_REZ2 = 4'd6,
    CALC_REZ  = 4'd7,
    CALC_REY  = 4'd8,
    DISP_REY  = 4'd9,
    DISP_IMY  = 4'd10,
    DISP_REZ  = 4'd11,
    DISP_IMZ  = 4'd12,
    CLEAR     = 4'd13
  } drv_step_t;

`ifdef FFT_DRV_CLEAR_STEP_EN
  localparam drv_step_t LAST_STEP = CLEAR;
`else
  localparam drv_step_t LAST_STEP = DISP_IMZ;
`endif

  // Steps whose press carries an operand byte on dataIn.
  function automatic logic is_data_step(input drv_step_t s);
    return (s == STORE_W) || (s == STORE_B) || (s == STORE_A);
  endfunction

  // Steps during which the butterfly shows a result byte.
  function automatic logic is_disp_step(input drv_step_t s);
    return (s == DISP_REY) || (s == DISP_IMY) || (s == DISP_REZ) || (s == DISP_IMZ);
  endfunction

  // Byte lane of out_data for a display step: ReY is the top byte.
  function automatic logic [1:0] disp_byte_index(input drv_step_t s);
    case (s)
      DISP_REY: return 2'd3;
      DISP_IMY: return 2'd2;
      DISP_REZ: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fft_butterfly_driver_press_timer.sv
// Loadable down-counter with zero flag; times both the press and gap phases.
module press_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/fft_butterfly_driver.sv
// Host-side sequencer that replays the butterfly's button-paced press
// sequence for one operand set and collects the four displayed bytes.
// Build option: FFT_DRV_CLEAR_STEP_EN issues the final CLEAR press.
module fft_butterfly_driver
  import fft_drv_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_w,
  input  logic [7:0]  in_b,
  input  logic [7:0]  in_a,
  output logic [7:0]  dataIn,
  output logic        ReadyIn,
  input  logic [7:0]  result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int unsigned TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  drv_state_t state_q, state_n;
  drv_step_t  step_q, step_n;

  logic [7:0]  b_q, a_q;
  logic [7:0]  data_q, data_n;
  logic        ready_q, ready_in_n;
  logic        in_ready_q, in_ready_n;
  logic        out_valid_q, out_valid_n;
  logic [31:0] out_data_q;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;
  logic          latch_en;
  logic          capture_en;

  press_timer #(.WIDTH(TW)) u_timer (
    .clk        (Clock),
    .rst        (Reset),
    .load       (timer_load),
    .load_value (timer_val),
    .zero       (timer_zero)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port is driven straight from a flop.
  always_comb begin
    state_n     = state_q;
    step_n      = step_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    data_n      = data_q;
    ready_in_n  = ready_q;
    out_valid_n = out_valid_q;
    latch_en    = 1'b0;
    capture_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          latch_en   = 1'b1;
          state_n    = PRESS;
          step_n     = STORE_W;
          timer_load = 1'b1;
          timer_val  = HOLD_LOAD;
          ready_in_n = 1'b1;
          data_n     = in_w;
        end
      end
      PRESS: begin
        if (timer_zero) begin
          state_n    = GAP;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
          ready_in_n = 1'b0;
        end
      end
      GAP: begin
        if (timer_zero) begin
          capture_en = is_disp_step(step_q);
          if (step_q == LAST_STEP) begin
            state_n     = DONE;
            out_valid_n = 1'b1;
          end else begin
            state_n    = PRESS;
            step_n     = drv_step_t'(step_q + 4'd1);
            timer_load = 1'b1;
            timer_val  = HOLD_LOAD;
            ready_in_n = 1'b1;
            // W is only ever loaded at accept, so a later data step is B or A.
            data_n     = '0;
            if (is_data_step(step_n)) begin
              data_n = (step_n == STORE_B) ? b_q : a_q;
            end
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n = (state_n == IDLE);
  end

  // State, step, operand latches and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      step_q      <= STORE_W;
      b_q         <= '0;
      a_q         <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_n;
      step_q      <= step_n;
      data_q      <= data_n;
      ready_q     <= ready_in_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      if (latch_en) begin
        b_q <= in_b;
        a_q <= in_a;
      end
      if (capture_en) begin
        out_data_q[{disp_byte_index(step_q), 3'b000} +: 8] <= result;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign dataIn    = data_q;
  assign ReadyIn   = ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fft_butterfly_driver.sv
// Self-checking bench for fft_butterfly_driver with a behavioural butterfly
// responder that counts presses and shows result bytes on display steps.
module tb_fft_butterfly_driver;

  localparam int unsigned HOLD = 4;
  localparam int unsigned GAP  = 4;
  localparam int unsigned P    = HOLD + GAP;
`ifdef FFT_DRV_CLEAR_STEP_EN
  localparam int unsigned NSTEPS = 14;
`else
  localparam int unsigned NSTEPS = 13;
`endif
  localparam int unsigned LIM = NSTEPS * P + 20;

  logic        clk;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_w, in_b, in_a;
  logic [7:0]  dataIn;
  logic        ReadyIn;
  logic [7:0]  result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] disp_cur;
  int          presses;
  logic        prev_r;

  fft_butterfly_driver #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .Clock     (clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_b      (in_b),
    .in_a      (in_a),
    .dataIn    (dataIn),
    .ReadyIn   (ReadyIn),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Butterfly stand-in: press k puts the controller in step k (mod sequence
  // length); steps 9..12 show ReY, ImY, ReZ, ImZ, anything else is noise.
  initial begin
    int pos;
    presses = 0;
    prev_r  = 1'b0;
    result  = 8'h00;
    forever begin
      @(negedge clk);
      if (Reset) begin
        presses = 0;
        prev_r  = 1'b0;
      end else begin
        if (ReadyIn && !prev_r) presses++;
        prev_r = ReadyIn;
      end
      pos = (presses > 0) ? (presses - 1) % NSTEPS : -1;
      if (pos >= 9 && pos <= 12) result = 8'(disp_cur >> (8 * (12 - pos)));
      else                       result = 8'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [7:0] w, b, a);
    case (k)
      0:       return w;
      1:       return b;
      5:       return a;
      default: return 8'h00;
    endcase
  endfunction

  // One full operand transaction; nv/nw/nb/na are what the host shows on the
  // input side while the driver is busy and at the result handshake.
  task automatic run_txn(input logic [7:0] w, b, a, input logic [31:0] d, input int bp,
                         input logic nv, input logic [7:0] nw, nb, na);
    int          c, mism, rises, bad, k, ph;
    logic        pr, er;
    logic [31:0] held;
    in_w = w; in_b = b; in_a = a; in_valid = 1'b1; disp_cur = d;
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    tick;
    in_w = nw; in_b = nb; in_a = na;
    c = 1; mism = 0; rises = 0; pr = 1'b0;
    while (out_valid !== 1'b1 && c < LIM) begin
      if (c <= int'(NSTEPS * P)) begin
        k  = (c - 1) / P;
        ph = (c - 1) % P;
        er = (ph < int'(HOLD));
        if (ReadyIn !== er) mism++;
        if (dataIn !== exp_byte(k, w, b, a)) mism++;
        if (ReadyIn === 1'b1 && !pr) rises++;
        pr = ReadyIn;
      end else begin
        mism++;
      end
      tick;
      c++;
    end
    chk("latency", c, NSTEPS * P + 1);
    chk("trace", mism, 0);
    chk("pulses", rises, NSTEPS);
    chk("out_data", out_data, d);
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    held = out_data;
    bad  = 0;
    for (int i = 0; i < bp; i++) begin
      tick;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || ReadyIn !== 1'b0) bad++;
    end
    chk("backpressure", bad, 0);
    out_ready = 1'b1;
    in_valid  = nv;
    tick;
    out_ready = 1'b0;
    chk("ov_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_post", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0]  w2, b2, a2;
    logic [31:0] d2;
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_w = 8'h00; in_b = 8'h00; in_a = 8'h00; disp_cur = 32'h0;
    repeat (2) tick;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ReadyIn", {31'd0, ReadyIn}, 32'd0);
    chk("rst_dataIn", {24'd0, dataIn}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    Reset = 1'b0;
    tick;

    // Basic sequence with the directed operand and display values.
    run_txn(8'h02, 8'h03, 8'h01, 32'h11223344, 0, 1'b0, 8'h5A, 8'hA5, 8'h3C);

    // Long backpressure while in_valid is waved with other operands.
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), $urandom, 50, 1'b0,
            8'($urandom), 8'($urandom), 8'($urandom));

    // Reset during step 7 PRESS, then a fresh set completes.
    in_w = 8'h12; in_b = 8'h34; in_a = 8'h56; in_valid = 1'b1; disp_cur = 32'hDEADBEEF;
    tick;
    in_valid = 1'b0;
    repeat (7 * P + 1) tick;
    chk("mid_press_high", {31'd0, ReadyIn}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_ReadyIn", {31'd0, ReadyIn}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_dataIn", {24'd0, dataIn}, 32'd0);
    tick;
    Reset = 1'b0;
    tick;
    run_txn(8'hFF, 8'h80, 8'h7F, 32'hA1B2C3D4, 3, 1'b0, 8'h00, 8'h00, 8'h00);

    // Back-to-back: in_valid stays high through the handshake.
    w2 = 8'($urandom); b2 = 8'($urandom); a2 = 8'($urandom); d2 = $urandom;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), $urandom, 0, 1'b1, w2, b2, a2);
    run_txn(w2, b2, a2, d2, 0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Randomized operand sets with random short backpressure.
    for (int i = 0; i < 4; i++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), $urandom,
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
